pmsm_commutation_ctrl: RTL

Six-step commutation sequencer that drives the `V_phase` input of the PMSM motor model. It runs a fixed motor start-up: rotor alignment, then an open-loop frequency ramp, then steady run at a commanded step period. It also provides a timed brake on stop. It sits between the system control registers (enable, direction, target step period) and the PMSM model, replacing hand-written testbench phase stimulus with a cycle-exact, reproducible sequence.

---
 rtl/pmsm_commutation_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/pmsm_commutation_ctrl.sv
// Six-step commutation sequencer for the PMSM model.
// Start-up runs rotor alignment, then an open-loop dwell ramp, then steady
// RUN at the commanded step period. Dropping en applies a timed brake vector.
// All outputs are registered; a single down-counter times every phase.
module pmsm_commutation_ctrl #(
    parameter int DWELL_W      = 16,
    parameter int ALIGN_CYCLES = 64,
    parameter int START_DWELL  = 200,
    parameter int RAMP_STEP    = 4,
    parameter int BRAKE_CYCLES = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               dir,
    input  logic [DWELL_W-1:0] target_dwell,
    output logic [2:0]         V_phase,
    output logic [2:0]         step_idx,
    output logic [2:0]         state,
    output logic               commutate,
    output logic               running
);

    // The counter must hold the largest of the align, brake and dwell loads.
    localparam int ALIGN_W = $clog2(ALIGN_CYCLES + 1);
    localparam int BRAKE_W = $clog2(BRAKE_CYCLES + 1);
    localparam int CNT_W0  = (ALIGN_W > BRAKE_W) ? ALIGN_W : BRAKE_W;
    localparam int CNT_W   = (CNT_W0 > DWELL_W) ? CNT_W0 : DWELL_W;

    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]   ALIGN_LOAD = CNT_W'(ALIGN_CYCLES - 1);
    localparam logic [CNT_W-1:0]   BRAKE_LOAD = CNT_W'(BRAKE_CYCLES - 1);
    localparam logic [DWELL_W-1:0] START_D    = DWELL_W'(START_DWELL);
    localparam logic [DWELL_W-1:0] RAMP_D     = DWELL_W'(RAMP_STEP);
    localparam logic [DWELL_W-1:0] MIN_D      = DWELL_W'(2);

    localparam logic [2:0] V_OFF   = 3'b000;
    localparam logic [2:0] V_BRAKE = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ALIGN = 3'd1,
        S_RAMP  = 3'd2,
        S_RUN   = 3'd3,
        S_BRAKE = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [2:0]         step_q, step_d;
    logic [2:0]         v_q, v_d;
    logic               comm_q, comm_d;
    logic               run_q, run_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DWELL_W-1:0] cur_dwell_q, cur_dwell_d;

    logic [DWELL_W-1:0] tgt;
    logic [DWELL_W-1:0] ramp_nxt;
    logic [2:0]         idx_adv;
    logic               cnt_done;

    // Forward step table; idx 0 doubles as the alignment vector.
    function automatic logic [2:0] step_code(input logic [2:0] idx);
        case (idx)
            3'd0:    step_code = 3'b001;
            3'd1:    step_code = 3'b011;
            3'd2:    step_code = 3'b010;
            3'd3:    step_code = 3'b110;
            3'd4:    step_code = 3'b100;
            3'd5:    step_code = 3'b101;
            default: step_code = V_OFF;
        endcase
    endfunction

    // Mod-6 step advance in either direction.
    function automatic logic [2:0] step_next(input logic [2:0] idx, input logic rev);
        if (rev) step_next = (idx == 3'd0) ? 3'd5 : idx - 3'd1;
        else     step_next = (idx >= 3'd5) ? 3'd0 : idx + 3'd1;
    endfunction

    // A step of d cycles counts d-1 down to 0 and ends on the edge after 0.
    function automatic logic [CNT_W-1:0] dwell_load(input logic [DWELL_W-1:0] d);
        dwell_load = CNT_W'(d) - CNT_ONE;
    endfunction

    // Commanded dwell is clamped to 2 so a step always spans at least two cycles.
    assign tgt      = (target_dwell < MIN_D) ? MIN_D : target_dwell;
    assign ramp_nxt = (cur_dwell_q > RAMP_D) ? (cur_dwell_q - RAMP_D) : '0;
    assign idx_adv  = step_next(step_q, dir);
    assign cnt_done = (cnt_q == '0);

    // State and output registers; async reset drops straight to IDLE with no brake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            step_q      <= 3'd0;
            v_q         <= V_OFF;
            comm_q      <= 1'b0;
            run_q       <= 1'b0;
            cnt_q       <= '0;
            cur_dwell_q <= START_D;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            v_q         <= v_d;
            comm_q      <= comm_d;
            run_q       <= run_d;
            cnt_q       <= cnt_d;
            cur_dwell_q <= cur_dwell_d;
        end
    end

    // Next-state and registered-output logic; brake request outranks a step boundary.
    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        v_d         = v_q;
        comm_d      = 1'b0;
        cnt_d       = cnt_done ? cnt_q : (cnt_q - CNT_ONE);
        cur_dwell_d = cur_dwell_q;

        case (state_q)
            S_IDLE: begin
                if (en) begin
                    state_d = S_ALIGN;
                    step_d  = 3'd0;
                    v_d     = step_code(3'd0);
                    cnt_d   = ALIGN_LOAD;
                end
            end

            S_ALIGN, S_RAMP, S_RUN: begin
                if (!en) begin
                    state_d = S_BRAKE;
                    v_d     = V_BRAKE;
                    cnt_d   = BRAKE_LOAD;
                end else if (cnt_done) begin
                    // Step boundary: dir and target_dwell are sampled only here.
                    step_d = idx_adv;
                    v_d    = step_code(idx_adv);
                    comm_d = 1'b1;
                    if (state_q == S_ALIGN) begin
                        state_d     = S_RAMP;
                        cur_dwell_d = START_D;
                        cnt_d       = dwell_load(START_D);
                    end else if (state_q == S_RAMP && ramp_nxt > tgt) begin
                        cur_dwell_d = ramp_nxt;
                        cnt_d       = dwell_load(ramp_nxt);
                    end else begin
                        // Ramp has reached the command, or already in RUN.
                        state_d     = S_RUN;
                        cur_dwell_d = tgt;
                        cnt_d       = dwell_load(tgt);
                    end
                end
            end

            S_BRAKE: begin
                if (cnt_done) begin
                    state_d = S_IDLE;
                    v_d     = V_OFF;
                end
            end

            default: begin
                state_d = S_IDLE;
                v_d     = V_OFF;
                cnt_d   = '0;
            end
        endcase

        run_d = (state_d == S_RUN);
    end

    assign V_phase   = v_q;
    assign step_idx  = step_q;
    assign state     = state_q;
    assign commutate = comm_q;
    assign running   = run_q;

endmodule
